// File: rtl/csla_bec_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor:
// segment-width helper, configuration legality check and the payload
// carried between pipeline stages.
package csla_bec_pkg;

    // Widest operand the stage payload can carry; covers 32- and 64-bit datapaths.
    localparam int MAX_W      = 64;
    localparam int MAX_STAGES = 8;

    // Bits of the operation completed by each pipeline stage.
    function automatic int seg_w(input int width, input int num_stages);
        return width / num_stages;
    endfunction

    // Legal configuration: 1..MAX_STAGES stages, WIDTH split evenly into
    // segments, and each segment split evenly into BLK_W blocks.
    function automatic bit cfg_ok(input int width, input int num_stages, input int blk_w);
        bit ok;
        ok = 1'b1;
        if (num_stages < 1 || num_stages > MAX_STAGES) begin
            ok = 1'b0;
        end else if (width < 1 || width > MAX_W || (width % num_stages) != 0) begin
            ok = 1'b0;
        end else if (blk_w < 1 || (seg_w(width, num_stages) % blk_w) != 0) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // What one stage hands to the next: operands (b already inverted for a
    // subtract), the low sum bits finished so far, and the carry into the
    // next segment. Bits above WIDTH stay zero.
    typedef struct packed {
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
        logic [MAX_W-1:0] psum;
        logic             carry;
    } stage_pl_t;

endpackage

// File: rtl/csla_bec_seg.sv
// Combinational SEG-bit carry-select segment. Each BLK_W block adds with a
// ripple-carry chain (carry-in 0), derives the +1 candidate with a
// binary-to-excess-1 converter, and a mux picks one on the block carry-in.
module csla_bec_seg #(
    parameter int SEG   = 16,
    parameter int BLK_W = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    localparam int NUM_BLK = SEG / BLK_W;

    logic [BLK_W-1:0] s0;     // block sum assuming carry-in 0
    logic [BLK_W-1:0] s1;     // block sum assuming carry-in 1 (s0 + 1)
    logic             c0;
    logic             c1;
    logic             rc;     // ripple carry inside the RCA
    logic             run;    // "all lower s0 bits are one" inside the BEC
    logic             carry;  // select carry between blocks

    // Walk the blocks LSB-first: RCA, BEC, then select on the incoming carry.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves one unassigned and no latch is inferred.
        s     = '0;
        s0    = '0;
        s1    = '0;
        c0    = 1'b0;
        c1    = 1'b0;
        rc    = 1'b0;
        run   = 1'b0;
        carry = cin;
        // NOTE: blocking assignments are intended here -- rc, run and carry
        // are chained through the loop; sequential state elsewhere uses <=.
        for (int j = 0; j < NUM_BLK; j++) begin
            rc = 1'b0;
            for (int i = 0; i < BLK_W; i++) begin
                s0[i] = a[j*BLK_W+i] ^ b[j*BLK_W+i] ^ rc;
                rc    = (a[j*BLK_W+i] & b[j*BLK_W+i]) | (rc & (a[j*BLK_W+i] ^ b[j*BLK_W+i]));
            end
            c0 = rc;

            // Excess-1: bit i toggles when every lower bit of s0 is one.
            run = 1'b1;
            for (int i = 0; i < BLK_W; i++) begin
                s1[i] = s0[i] ^ run;
                run   = run & s0[i];
            end
            // s0 all ones wraps to zero and carries; c0=1 with s0 all ones is unreachable.
            c1 = c0 | run;

            s[j*BLK_W +: BLK_W] = carry ? s1 : s0;
            carry               = carry ? c1 : c0;
        end
        cout = carry;
    end

endmodule

// File: rtl/csla_bec_pipe.sv
// Pipelined carry-select adder/subtractor. WIDTH bits are split into
// NUM_STAGES segments, one per register stage; the whole pipe advances
// together under a valid/ready handshake with a global stall.
// Optional macro CSLA_BEC_FLAGS_EN adds registered zero/ovf outputs.
module csla_bec_pipe
    import csla_bec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 2,
    parameter int BLK_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSLA_BEC_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int SEG  = seg_w(WIDTH, NUM_STAGES);
    localparam int LAST = NUM_STAGES - 1;

    if (!cfg_ok(WIDTH, NUM_STAGES, BLK_W)) begin : g_cfg_check
        $error("csla_bec_pipe: illegal WIDTH/NUM_STAGES/BLK_W combination");
    end

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;
    stage_pl_t             stage_in [NUM_STAGES];  // payload entering each segment
    stage_pl_t             pipe_d   [NUM_STAGES];  // payload leaving each segment
    stage_pl_t             pipe_q   [NUM_STAGES];  // stage registers
    logic [SEG-1:0]        seg_s    [NUM_STAGES];
    logic                  seg_c    [NUM_STAGES];
    logic                  advance;
    logic                  unused_acc;

    // The pipe moves only when the output slot is empty or being drained.
    assign advance   = ~valid_q[LAST] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[LAST];
    assign sum       = pipe_q[LAST].psum[WIDTH-1:0];
    assign cout      = pipe_q[LAST].carry;

    // Stage 0 applies the subtract (invert b, force carry-in); later stages
    // consume the previous stage register unchanged.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_in[k] = '0;
        end
        stage_in[0].a[WIDTH-1:0] = a;
        stage_in[0].b[WIDTH-1:0] = sub ? ~b : b;
        stage_in[0].carry        = sub | cin;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_in[k] = pipe_q[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        csla_bec_seg #(
            .SEG   (SEG),
            .BLK_W (BLK_W)
        ) u_seg (
            .a    (stage_in[k].a[k*SEG +: SEG]),
            .b    (stage_in[k].b[k*SEG +: SEG]),
            .cin  (stage_in[k].carry),
            .s    (seg_s[k]),
            .cout (seg_c[k])
        );
    end

    // Merge each segment's result into its payload: fill in this segment's
    // sum bits and replace the carry with the segment carry-out.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            pipe_d[k]                     = stage_in[k];
            pipe_d[k].psum[k*SEG +: SEG]  = seg_s[k];
            pipe_d[k].carry               = seg_c[k];
        end
    end

    // Valid bits shift one stage per advance, new op entering at stage 0.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    // Stage registers: every stage holds together when the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            // NOTE: data registers are reset as well so sum/cout read zero
            // straight out of reset, not just when out_valid is low.
            for (int k = 0; k < NUM_STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < NUM_STAGES; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    // Operand copies in the last stage and payload bits above WIDTH have no
    // consumer; fold them into one sink so their non-use is explicit.
    always_comb begin
        unused_acc = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            unused_acc = unused_acc ^ (^pipe_q[k]);
        end
    end

`ifdef CSLA_BEC_FLAGS_EN
    logic zero_q;
    logic zero_d;
    logic ovf_q;
    logic ovf_d;

    // Flags from the final segment's result; the carry into the MSB is
    // recovered as sum ^ a ^ b at that bit.
    always_comb begin
        zero_d = (pipe_d[LAST].psum[WIDTH-1:0] == '0);
        ovf_d  = pipe_d[LAST].psum[WIDTH-1] ^ pipe_d[LAST].a[WIDTH-1]
               ^ pipe_d[LAST].b[WIDTH-1] ^ pipe_d[LAST].carry;
    end

    // Flag registers advance in lockstep with the final stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csla_bec_pipe.sv
// Directed bench for csla_bec_pipe: default 32-bit/2-stage instance plus a
// 64-bit/4-stage/BLK_W=8 instance (flags checked when CSLA_BEC_FLAGS_EN is set).
module tb_csla_bec_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 32-bit DUT
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;
    // 64-bit DUT
    logic        iv64, ir64, cin64, sub64, ov64, or64, cout64;
    logic [63:0] a64, b64, sum64;
`ifdef CSLA_BEC_FLAGS_EN
    logic        zero32, ovf32, zero64, ovf64;
`endif

    csla_bec_pipe #(.WIDTH(32), .NUM_STAGES(2), .BLK_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CSLA_BEC_FLAGS_EN
        , .zero(zero32), .ovf(ovf32)
`endif
    );

    csla_bec_pipe #(.WIDTH(64), .NUM_STAGES(4), .BLK_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .cin(cin64), .sub(sub64), .out_valid(ov64),
        .out_ready(or64), .sum(sum64), .cout(cout64)
`ifdef CSLA_BEC_FLAGS_EN
        , .zero(zero64), .ovf(ovf64)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [32:0] r;
        r = {1'b0, x} + {1'b0, (s ? ~y : y)} + {32'b0, (s | c)};
        return r;
    endfunction

    // Output scoreboard for the 32-bit DUT: every handshaken result must
    // match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum32", 64'(sum), 64'(e.sum));
                check("cout32", 64'(cout), 64'(e.cout));
`ifdef CSLA_BEC_FLAGS_EN
                check("zero32", 64'(zero32), 64'(e.sum == 32'h0));
                check("ovf32", 64'(ovf32), 64'(e.ovf));
`endif
            end
        end
    end

    // Present one op; record its expectation on the cycle it is accepted.
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                        input logic vsub, input logic [31:0] esum, input logic ecout);
        exp_t        e;
        logic [31:0] beff;
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        beff   = vsub ? ~vb : vb;
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = (va[31] == beff[31]) && (esum[31] != va[31]);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run64(input logic [63:0] va, input logic [63:0] vb, input logic vcin,
                         input logic vsub, input logic [63:0] esum, input logic ecout,
                         input logic ezero, input logic eovf);
        int lat;
        a64 = va; b64 = vb; cin64 = vcin; sub64 = vsub; iv64 = 1'b1;
        @(negedge clk);
        check("in_ready64", 64'(ir64), 64'd1);
        @(posedge clk); #1;
        iv64 = 1'b0;
        lat  = 1;
        while (!ov64 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency64", 64'(lat), 64'd4);
        @(negedge clk);
        check("sum64", sum64, esum);
        check("cout64", 64'(cout64), 64'(ecout));
`ifdef CSLA_BEC_FLAGS_EN
        check("zero64", 64'(zero64), 64'(ezero));
        check("ovf64", 64'(ovf64), 64'(eovf));
`else
        if (ezero && eovf) $display("note: 64-bit flag expectations not exercised");
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish by 200000");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[11];

    initial begin
        logic [32:0] r;
        int          t0;
        int          lat;

        vecs = '{
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0},
            '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1},
            '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0},
            '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0},
            '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1},
            '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0},
            '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1},
            '{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0},
            '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0}
        };

        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_out_valid64", 64'(ov64), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Single op: all-ones + 1 ripples through both segments; latency 2.
        send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, vecs[0].sum, vecs[0].cout);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency32", 64'(lat), 64'd2);
        drain();

        // Directed table, back to back.
        for (int i = 1; i < 11; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sum, vecs[i].cout);
        end
        drain();

        // 100-op stream: must accept one per cycle and return in order.
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra, rb;
            logic        rc, rs;
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(1)); rs = (i % 4 == 3);
            r  = model(ra, rb, rc, rs);
            send(ra, rb, rc, rs, r[31:0], r[32]);
        end
        check("stream_cycles", 64'(cyc - t0), 64'd100);
        drain();

        // Stall with the pipe full, then pop and accept in the same cycle.
        out_ready = 1'b0;
        send(32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0);
        send(32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0);
        fork
            send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_sum", 64'(sum), 64'h3);
                    check("stall_cout", 64'(cout), 64'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight: cleared at once, nothing emitted later.
        send(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0300, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum", 64'(sum), 64'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // 64-bit, 4 stages, BLK_W=8.
        run64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        run64(64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        run64(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/csla_bec_pipe.md
Name: csla_bec_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor.
- Each segment uses a ripple-carry adder with carry-in 0 plus a binary-to-excess-1 converter (BEC) to form both candidate sums; a mux selects between them using the incoming carry.
- The WIDTH-bit operation is split across NUM_STAGES register stages, with a valid/ready handshake and global stall.
- Used as the datapath adder where 32/64-bit adds must close timing at clock rate.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of NUM_STAGES.
- NUM_STAGES, 2, pipeline stages (1..8); per-stage segment SEG = WIDTH/NUM_STAGES.
- BLK_W, 4, carry-select block width inside a segment; must divide SEG.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: a - b (b inverted, carry-in forced 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for sub, 1 means no borrow.

Behaviour:
- Clock and reset: single clock clk; reset rst_n asynchronous active-low.
- Reset values: all stage valid flags 0, all data registers 0. So out_valid=0, sum=0, cout=0. in_ready=1 one cycle after reset release.
- Stall rule:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - A transfer occurs on in_valid & in_ready.
  - When advance=0, every stage holds (data and valid); there are no bubbles inside a stall.
- Stage k (0-based):
  - Computes sum bits [k*SEG +: SEG] from the registered carry of stage k-1 (stage 0 uses cin, or 1 when sub=1).
  - Passes the higher operand bits and the completed low sum bits forward.
  - The final stage registers sum/cout.
- Inside a segment, each BLK_W block:
  - RCA(carry-in 0) gives s0,c0.
  - BEC(s0,c0) gives s0+1 and c1.
  - A 2:1 mux selects on the block carry-in.
- Latency: exactly NUM_STAGES cycles from accept to out_valid when out_ready is held 1. Throughput: 1 op/cycle.
- Handshake rules:
  - sub and b inversion are applied at stage 0 only.
  - Later stages carry the already-inverted b.
  - Results emerge strictly in acceptance order.
  - out_valid stays high and sum/cout stay stable until out_ready=1.
- Boundary conditions:
  - Carry rippling through every segment (e.g. all-ones + 1) must produce sum=0, cout=1.
  - Simultaneous output pop and input accept in the same cycle is legal when the pipe is full.
- Reset mid-operation: in-flight ops are discarded; nothing is emitted after reset.

Optional Feature:
- Macro: CSLA_BEC_FLAGS_EN.
- When defined, two extra output ports exist, registered alongside sum:
  - zero  out  1: sum==0.
  - ovf  out  1: signed overflow; MSB carry-in XOR cout.
- Both reset to 0.
- When undefined, these ports and their logic are absent.
- Sum/cout timing is identical either way.

Decomposition:
- Package csla_bec_pkg holds:
  - function seg_w(WIDTH, NUM_STAGES);
  - localparam checks as elaboration-time assertions (divisibility, NUM_STAGES range);
  - the stage-payload struct typedef (remaining a/b, partial sum, carry).
- One sub-module, csla_bec_seg: combinational SEG-bit carry-select segment built from BLK_W RCA + BEC + mux blocks (parameters SEG, BLK_W).
- csla_bec_pipe instantiates NUM_STAGES segments and owns registers and handshake.

Test Plan:
- Defaults, out_ready=1, single op a=0xFFFFFFFF, b=0x00000001, cin=0 -> 2 cycles later out_valid=1, sum=0x00000000, cout=1.
- sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0. Second op sub=1, a=7, b=5 -> sum=2, cout=1.
- Back-to-back stream of 100 random ops with out_ready=1 -> one result per cycle, in order, matching a+b+cin modulo 2^32.
- out_ready=0 for 5 cycles with the pipe full:
  - in_ready=0 and out_valid/sum stable throughout;
  - after release, the queued results come out in order with none lost.
- Assert rst_n=0 with 2 ops in flight -> out_valid=0 and sum=0 immediately (asynchronous); no stale result after deassertion.
- WIDTH=64, NUM_STAGES=4, BLK_W=8, with CSLA_BEC_FLAGS_EN defined:
  - a=0x7FFFFFFFFFFFFFFF, b=1 -> ovf=1, zero=0.
  - a=b=0 -> zero=1.
